temp_sample_filter: RTL and testbench

TEMP_SAMPLE_FILTER -- requirements
Module: temp_sample_filter

---
 rtl/temp_sample_filter.sv | 111 +++++++++++
 tb/tb_temp_sample_filter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/temp_sample_filter.sv
// Temperature sample filter: windowed averaging, sensor timeout, spike rejection.
// Optional spike rejection in RUN is enabled by defining TEMP_SPIKE_REJECT_EN.
module temp_sample_filter #(
  parameter int AVG_LOG2    = 2,
  parameter int SPIKE_TH    = 20,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_valid,
  input  logic [7:0] raw_temp,
  output logic [7:0] temp_data,
  output logic       temp_valid,
  output logic       sensor_fault,
  output logic [7:0] reject_cnt
);

  localparam int AW = 8 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam int IW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'((1 << AVG_LOG2) - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    FILL,
    RUN,
    FAULT
  } state_t;

  state_t        state;
  logic [AW-1:0] acc;
  logic [AW-1:0] sum;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idle;
  logic [7:0]    avg;
  logic          spike;

  // Running sum including the current sample; the window mean is its top byte.
  always_comb begin
    sum = acc + AW'(raw_temp);
    avg = sum[AW-1:AVG_LOG2];
  end

`ifdef TEMP_SPIKE_REJECT_EN
  logic [7:0] diff;

  // Distance from the current reference; only meaningful once RUN has one.
  always_comb begin
    diff  = (raw_temp >= temp_data) ? raw_temp - temp_data
                                    : temp_data - raw_temp;
    spike = (state == RUN) && (diff > 8'(SPIKE_TH));
  end

  // Saturating count of discarded spike samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reject_cnt <= '0;
    end else if (raw_valid && spike && reject_cnt != 8'hFF) begin
      reject_cnt <= reject_cnt + 8'd1;
    end
  end
`else
  assign spike      = 1'b0;
  assign reject_cnt = '0;
`endif

  // Window accumulation, output update, idle timeout and state sequencing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= FILL;
      acc          <= '0;
      cnt          <= '0;
      idle         <= '0;
      temp_data    <= '0;
      temp_valid   <= 1'b0;
      sensor_fault <= 1'b0;
    end else begin
      temp_valid <= 1'b0;
      if (raw_valid) begin
        idle <= '0;
        if (!spike) begin
          sensor_fault <= 1'b0;
          if (cnt == CNT_LAST) begin
            temp_data  <= avg;
            temp_valid <= 1'b1;
            acc        <= '0;
            cnt        <= '0;
            state      <= RUN;
          end else begin
            acc <= sum;
            cnt <= cnt + CW'(1);
            if (state == FAULT) begin
              state <= FILL;
            end
          end
        end
      end else if (state != FAULT) begin
        if (idle == IDLE_LAST) begin
          state        <= FAULT;
          sensor_fault <= 1'b1;
          acc          <= '0;
          cnt          <= '0;
        end else begin
          idle <= idle + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_temp_sample_filter.sv
// Bench for temp_sample_filter: scoreboard of window averages plus a
// per-cycle reference model for held data, fault level and reject count.
module tb_temp_sample_filter;

  localparam int L   = 2;
  localparam int TH  = 20;
  localparam int TO  = 1000;
  localparam int WIN = 1 << L;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       raw_valid = 1'b0;
  logic [7:0] raw_temp = 8'd0;
  logic [7:0] temp_data;
  logic       temp_valid;
  logic       sensor_fault;
  logic [7:0] reject_cnt;

  int checks = 0;
  int errors = 0;

  int sb[$];
  int win_q[$];
  int mref  = 0;
  int mrej  = 0;
  int midle = 0;
  bit mfault = 1'b0;
  bit mrun   = 1'b0;

  temp_sample_filter #(
    .AVG_LOG2(L),
    .SPIKE_TH(TH),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .raw_valid(raw_valid),
    .raw_temp(raw_temp),
    .temp_data(temp_data),
    .temp_valid(temp_valid),
    .sensor_fault(sensor_fault),
    .reject_cnt(reject_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge with the given input.
  task automatic model_step(bit v, int t);
    bit accept;
    int d;
    int s;
    if (v) begin
      midle  = 0;
      accept = 1'b1;
`ifdef TEMP_SPIKE_REJECT_EN
      d = t - mref;
      if (d < 0) d = -d;
      if (mrun && d > TH) begin
        accept = 1'b0;
        if (mrej < 255) mrej++;
      end
`endif
      if (accept) begin
        mfault = 1'b0;
        win_q.push_back(t);
        if (win_q.size() == WIN) begin
          s = 0;
          foreach (win_q[i]) s += win_q[i];
          mref = s / WIN;
          sb.push_back(mref);
          win_q.delete();
          mrun = 1'b1;
        end
      end
    end else if (!mfault) begin
      midle++;
      if (midle == TO) begin
        mfault = 1'b1;
        mrun   = 1'b0;
        win_q.delete();
      end
    end
  endtask

  task automatic cycle(bit v, int t);
    @(negedge clk);
    chk("temp_data", temp_data, mref);
    chk("sensor_fault", sensor_fault, mfault);
    chk("reject_cnt", reject_cnt, mrej);
    raw_valid = v;
    raw_temp  = 8'(t);
    model_step(v, t);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    raw_valid = 1'b0;
    mref  = 0;
    mrej  = 0;
    midle = 0;
    mfault = 1'b0;
    mrun   = 1'b0;
    win_q.delete();
    #1;
    chk("rst_temp_data", temp_data, 0);
    chk("rst_temp_valid", temp_valid, 0);
    chk("rst_sensor_fault", sensor_fault, 0);
    chk("rst_reject_cnt", reject_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic burst(int t, int n);
    for (int i = 0; i < n; i++) cycle(1'b1, t);
  endtask

  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0);
  endtask

  // Monitor: every temp_valid pulse must match the oldest expected average.
  always @(negedge clk) begin
    if (!reset && temp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_temp_valid: got data %0d expected no pulse",
                 temp_data);
      end else begin
        chk("window_avg", temp_data, sb.pop_front());
      end
    end
  end

  initial begin
    int t;
    int r;
    do_reset();

    // Basic average with truncation.
    cycle(1'b1, 20);
    cycle(1'b1, 21);
    cycle(1'b1, 22);
    cycle(1'b1, 23);
    cycle(1'b0, 0);
    chk("avg_20_23", temp_data, 21);
    chk("avg_pulse", temp_valid, 1);
    cycle(1'b0, 0);
    chk("pulse_one_cycle", temp_valid, 0);

    // Establish RUN at 100, then a spike in the middle of a window.
    do_reset();
    burst(100, 4);
    cycle(1'b1, 100);
    cycle(1'b1, 150);
    cycle(1'b1, 100);
    cycle(1'b1, 100);
    cycle(1'b1, 100);
    cycle(1'b0, 0);
`ifdef TEMP_SPIKE_REJECT_EN
    chk("spike_reject_cnt", reject_cnt, 1);
`else
    chk("no_reject_cnt", reject_cnt, 0);
`endif

    // Sensor timeout, then recovery with a fresh window.
    idle_cycles(TO);
    cycle(1'b0, 0);
    chk("timeout_fault", sensor_fault, 1);
    chk("fault_hold", temp_data, mref);
    cycle(1'b1, 50);
    cycle(1'b1, 50);
    chk("fault_clear", sensor_fault, 0);
    cycle(1'b1, 50);
    cycle(1'b1, 50);
    cycle(1'b0, 0);
    chk("recover_50", temp_data, 50);

    // Reset mid-window discards the partial window.
    burst(80, 2);
    do_reset();
    burst(40, 4);
    cycle(1'b0, 0);
    chk("after_reset_40", temp_data, 40);

    // Full-scale window, then raw_valid on the timeout-reaching cycle.
    do_reset();
    burst(255, 4);
    cycle(1'b0, 0);
    chk("full_scale", temp_data, 255);
    idle_cycles(TO - 2);
    cycle(1'b1, 255);
    cycle(1'b0, 0);
    chk("valid_beats_timeout", sensor_fault, 0);

    // Randomised traffic around the current reference.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        t = int'($urandom_range(0, 255));
      end else begin
        r = int'($urandom_range(0, 50)) - 25;
        t = mref + r;
        if (t < 0) t = 0;
        if (t > 255) t = 255;
      end
      cycle($urandom_range(0, 2) != 0, t);
      if (k == 300) idle_cycles(TO + 5);
    end

    idle_cycles(4);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
